// File: rtl/mul_pkg.sv
// Shared widths and FSM state encoding for the sequential 32x32 multiplier.
package mul_pkg;

    localparam int A_W    = 32;
    localparam int B_W    = 32;
    localparam int BYTE_W = 8;
    localparam int PP_W   = 40;
    localparam int P_W    = 64;
    localparam int NSTEP  = 4;
    localparam int IDX_W  = $clog2(NSTEP);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } mulState_t;

endpackage

// File: rtl/bit32_MUL.sv
// Combinational 32x8 unsigned array multiplier producing a 40-bit partial product.
module bit32_MUL
    import mul_pkg::*;
(
    input  logic [A_W-1:0]    a,
    input  logic [BYTE_W-1:0] b,
    output logic [PP_W-1:0]   pp
);

    always_comb begin
        pp = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) begin
                pp = pp + ({{(PP_W-A_W){1'b0}}, a} << i);
            end
        end
    end

endmodule

// File: rtl/mul32_seq_ctrl.sv
// 32x32 unsigned multiplier: one B byte per cycle through a shared 32x8 array,
// accumulated into a 64-bit product, with valid/ready on both sides.
module mul32_seq_ctrl
    import mul_pkg::*;
#(
    parameter int EARLY_EXIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] in_a,
    input  logic [B_W-1:0] in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] out_p,
    output logic           busy
);

    mulState_t        state;
    mulState_t        stateNext;
    logic [A_W-1:0]   aReg;
    logic [B_W-1:0]   bReg;
    logic [P_W-1:0]   acc;
    logic [P_W-1:0]   accSum;
    logic [P_W-1:0]   outP;
    logic [IDX_W-1:0] idx;
    logic [BYTE_W-1:0] bByte;
    logic [PP_W-1:0]  pp;
    logic             accept;
    logic             highZero;
    logic             lastStep;

    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_p     = outP;

    assign bByte = bReg[BYTE_W*idx +: BYTE_W];

    bit32_MUL uArray (
        .a  (aReg),
        .b  (bByte),
        .pp (pp)
    );

    assign accSum = acc + ({{(P_W-PP_W){1'b0}}, pp} << {idx, 3'b000});

    // Early exit once every byte above the current one is zero.
    always_comb begin
        highZero = 1'b1;
        unique case (idx)
            2'd0:    highZero = (bReg[B_W-1:8] == '0);
            2'd1:    highZero = (bReg[B_W-1:16] == '0);
            2'd2:    highZero = (bReg[B_W-1:24] == '0);
            default: highZero = 1'b1;
        endcase
    end

    assign lastStep = (idx == 2'd3) || ((EARLY_EXIT != 0) && highZero);

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (accept) stateNext = MUL;
            MUL:  if (lastStep) stateNext = DONE;
            DONE: if (out_ready) stateNext = in_valid ? MUL : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            aReg  <= '0;
            bReg  <= '0;
            acc   <= '0;
            idx   <= '0;
            outP  <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                aReg <= in_a;
                bReg <= in_b;
                acc  <= '0;
                idx  <= '0;
            end else if (state == MUL) begin
                acc <= accSum;
                idx <= idx + 2'd1;
                if (lastStep) outP <= accSum;
            end
        end
    end

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Directed bench for mul32_seq_ctrl with early exit on and off.
module tb_mul32_seq_ctrl;

    logic        clk = 0;
    logic        rst;
    logic        inValid, inReady, outValid, outReady, busy;
    logic [31:0] inA, inB;
    logic [63:0] outP;

    logic        inValidX, inReadyX, outValidX, outReadyX, busyX;
    logic [31:0] inAX, inBX;
    logic [63:0] outPX;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    mul32_seq_ctrl #(.EARLY_EXIT(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady),
        .in_a(inA), .in_b(inB),
        .out_valid(outValid), .out_ready(outReady),
        .out_p(outP), .busy(busy)
    );

    mul32_seq_ctrl #(.EARLY_EXIT(0)) dutX (
        .clk(clk), .rst(rst),
        .in_valid(inValidX), .in_ready(inReadyX),
        .in_a(inAX), .in_b(inBX),
        .out_valid(outValidX), .out_ready(outReadyX),
        .out_p(outPX), .busy(busyX)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expP, input int expN, input string tag);
        int n;
        inA = a;
        inB = b;
        inValid = 1;
        check({tag, "_inReady"}, inReady, 1);
        tick();
        inValid = 0;
        n = 0;
        while (!outValid && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, expN);
        check({tag, "_p"}, outP, expP);
        check({tag, "_busy"}, busy, 1);
    endtask

    initial begin
        int n;
        logic [63:0] heldP;
        rst = 1;
        inValid = 0; inA = 0; inB = 0; outReady = 0;
        inValidX = 0; inAX = 0; inBX = 0; outReadyX = 0;
        tick();
        tick();
        check("rst_inReady", inReady, 0);
        check("rst_outValid", outValid, 0);
        check("rst_outP", outP, 0);
        check("rst_busy", busy, 0);
        rst = 0;
        #1;
        check("idle_inReady", inReady, 1);

        outReady = 1;
        runOp(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 4, "max");
        tick();
        check("max_consumed", outValid, 0);

        runOp(32'h12345678, 32'h000000FF, 64'h0000001222222188, 1, "lowByte");
        tick();

        runOp(32'h80000000, 32'h01000000, 64'h0080000000000000, 4, "topByte");
        tick();

        outReady = 0;
        runOp(32'h00001000, 32'h00000300, 64'h0000000000300000, 2, "bp");
        heldP = outP;
        for (int i = 0; i < 10; i++) begin
            inValid = i[0];
            inA = 32'h0000_0009;
            inB = 32'h0000_0009;
            #1;
            check("bp_inReady", inReady, 0);
            tick();
            check("bp_outValid", outValid, 1);
            check("bp_outP", outP, heldP);
        end
        inValid = 0;
        outReady = 1;
        tick();
        check("bp_release_valid", outValid, 0);
        check("bp_release_busy", busy, 0);
        tick();
        check("bp_single_handshake", outValid, 0);

        outReady = 0;
        runOp(32'h12345678, 32'h000000FF, 64'h0000001222222188, 1, "b2b_first");
        outReady = 1;
        inValid = 1;
        inA = 3;
        inB = 5;
        #1;
        check("b2b_inReady", inReady, 1);
        tick();
        inValid = 0;
        check("b2b_gap_valid", outValid, 0);
        check("b2b_gap_busy", busy, 1);
        tick();
        check("b2b_valid", outValid, 1);
        check("b2b_p", outP, 15);
        check("b2b_busy", busy, 1);
        tick();

        inA = 32'hFFFFFFFF;
        inB = 32'hFFFFFFFF;
        inValid = 1;
        tick();
        inValid = 0;
        tick();
        tick();
        rst = 1;
        #1;
        check("abort_inReady_in_rst", inReady, 0);
        tick();
        check("abort_outValid", outValid, 0);
        check("abort_busy", busy, 0);
        rst = 0;
        #1;
        check("abort_inReady_after", inReady, 1);
        runOp(32'd7, 32'd6, 64'd42, 1, "afterAbort");
        tick();

        outReadyX = 1;
        inAX = 32'h12345678;
        inBX = 32'h000000FF;
        inValidX = 1;
        #1;
        check("noExit_inReady", inReadyX, 1);
        tick();
        inValidX = 0;
        n = 0;
        while (!outValidX && n < 8) begin
            tick();
            n++;
        end
        check("noExit_latency", n, 4);
        check("noExit_p", outPX, 64'h0000001222222188);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/mul32_seq_ctrl.md
Name: mul32_seq_ctrl

Overview:
Sequencing controller that computes a full 32x32 unsigned product over up to four cycles. It reuses one 32x8 array-multiplier datapath, feeding it one byte of B per step and accumulating the shifted 40-bit partial products into a 64-bit register. A valid/ready handshake sits on both the operand input and the result output. It is the team's area-lean wide multiplier, used wherever a single-cycle 32x32 array is too large.

Parameters:
EARLY_EXIT, 1, when 1, finish as soon as all remaining (higher) bytes of B are zero; when 0, always run 4 steps.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
in_a  input  32  multiplicand A (unsigned)
in_b  input  32  multiplier B (unsigned)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_p  output  64  product A*B
busy  output  1  high in MUL or DONE

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state=IDLE, acc=0, idx=0, out_valid=0, out_p=0, busy=0.
- in_ready is 0 while rst is high. After reset is released it is combinational: in_ready = (state==IDLE) | (state==DONE & out_ready).
- FSM states: IDLE, MUL, DONE.
- IDLE: on in_valid & in_ready, capture a_reg=in_a, b_reg=in_b, set acc=0, idx=0, and go to MUL.
- MUL, one step per cycle:
  - pp[39:0] = a_reg * b_reg[8*idx +: 8], produced by the datapath sub-module.
  - acc <= acc + (pp << 8*idx), computed at 64-bit width. No overflow is possible.
  - idx <= idx+1.
- MUL exits to DONE when idx==3, or when EARLY_EXIT=1 and b_reg[31:8*(idx+1)]==0 (evaluated at idx 0..2).
- Step count n is always at least 1. B=0 takes one step and produces 0.
- Latency: out_valid rises n edges after the accepting edge (n=1..4). in_ready=0 throughout MUL.
- DONE: out_valid=1 and out_p=acc, both held stable until out_valid & out_ready.
  - Handshake with in_valid=0: go to IDLE, out_valid=0.
  - Handshake with in_valid=1 in the same cycle: capture the new operands and go directly to MUL. This gives back-to-back operation with no bubble.
- in_valid seen while in_ready=0 is ignored. Inputs are not sampled.
- out_p is registered and keeps its last value after the handshake; it is only meaningful while out_valid=1.
- Reset mid-operation: the operation is aborted with no result emitted. The next cycle after rst deasserts shows IDLE values.

Decomposition:
- Shared package mul_pkg:
  - Constants A_W=32, B_W=32, BYTE_W=8, PP_W=40, P_W=64, NSTEP=4.
  - State enum {IDLE, MUL, DONE}.
- One natural sub-module: the existing bit32_MUL combinational 32x8 array multiplier, instantiated once. It takes a_reg and the selected B byte and drives pp.
- Byte mux, shifter, accumulator and FSM are inline in mul32_seq_ctrl.

Test Plan:
- A=0xFFFFFFFF, B=0xFFFFFFFF, out_ready=1 -> out_p=0xFFFFFFFE00000001, out_valid 4 edges after accept.
- A=0x12345678, B=0x000000FF -> out_p=0x0000001222222188. With EARLY_EXIT=1 the result arrives after 1 step; with EARLY_EXIT=0 after 4 steps.
- A=0x80000000, B=0x01000000, EARLY_EXIT=1 -> out_p=0x0080000000000000 after 4 steps (top byte nonzero).
- Backpressure: hold out_ready=0 for 10 cycles and pulse in_valid -> out_valid and out_p stay stable, in_ready=0, pulses are ignored. Releasing out_ready gives exactly one handshake.
- Back-to-back: in DONE, out_ready=1 and in_valid=1 with A=3, B=5 -> first result consumed and new operands accepted on the same edge, then out_p=15 after 1 step, busy stays 1.
- Assert rst during step idx=2 -> next cycle out_valid=0, busy=0, and in_ready=1 after release. A following op A=7, B=6 gives out_p=42.
